// File: rtl/led_fade_driver.sv
// LED fade driver: requests one LFSR step per fade cycle, latches the pattern,
// and ramps each LED's PWM duty toward full-on or full-off at a divided tick rate.
module led_fade_driver #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    output logic             sample_req,
    output logic [WIDTH-1:0] led,
    output logic             busy
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2,
        FADE  = 2'd3
    } state_e;

    state_e                            state_q, state_d;
    logic [WIDTH-1:0]                  target_q, target_d;
    logic [WIDTH-1:0][PWM_BITS-1:0]    duty_q, duty_d;
    logic [PWM_BITS-1:0]               pwm_cnt_q;
    logic [DIV_W-1:0]                  div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0]                  led_q, led_d;
    logic                              sample_req_q;
    logic                              busy_q;
    logic                              done_c;
    logic                              tick_c;

    // Every LED has reached the endpoint selected by its target bit.
    always_comb begin
        done_c = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (duty_q[i] != (target_q[i] ? DUTY_MAX : '0)) begin
                done_c = 1'b0;
            end
        end
    end

    assign tick_c = (state_q == FADE) && (div_cnt_q == DIV_LAST);

    // Next-state, latch and saturating duty ramp.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        div_cnt_d = div_cnt_q;
        duty_d    = duty_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LATCH;
            end
            LATCH: begin
                target_d  = sample;
                div_cnt_d = '0;
                state_d   = FADE;
            end
            FADE: begin
                div_cnt_d = tick_c ? '0 : div_cnt_q + DIV_W'(1);
                if (tick_c) begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (target_q[i]) begin
                            if (duty_q[i] != DUTY_MAX) begin
                                duty_d[i] = duty_q[i] + PWM_BITS'(1);
                            end
                        end else if (duty_q[i] != '0) begin
                            duty_d[i] = duty_q[i] - PWM_BITS'(1);
                        end
                    end
                end
                if (done_c) begin
                    state_d = en ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // PWM compare against the current duty and counter.
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            led_d[i] = (duty_q[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            target_q     <= '0;
            duty_q       <= '0;
            pwm_cnt_q    <= '0;
            div_cnt_q    <= '0;
            led_q        <= '0;
            sample_req_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            duty_q       <= duty_d;
            pwm_cnt_q    <= pwm_cnt_q + PWM_BITS'(1);
            div_cnt_q    <= div_cnt_d;
            led_q        <= led_d;
            // Registered Moore outputs track the state being entered.
            sample_req_q <= (state_d == REQ);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign sample_req = sample_req_q;
    assign led        = led_q;
    assign busy       = busy_q;

endmodule
